// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the byte-addressed instruction memory.
// The optional IMEM_PARITY_EN build adds a per-byte parity bit in the storage.
package instr_mem_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_PARITY   = 2'b11
  } fetch_err_e;

  // Lane (byte position counted from the LSB) that holds the byte found at
  // address offset k inside an instruction of nbytes bytes.
  function automatic int byte_lane(input int k, input int nbytes, input bit big_endian);
    return big_endian ? (nbytes - 1 - k) : k;
  endfunction

endpackage

// File: rtl/instr_mem_bytearray.sv
// Byte storage for the instruction memory: one byte write port and an
// INSTR_BYTES-wide combinational read gather ordered by BIG_ENDIAN.
// With IMEM_PARITY_EN defined, each byte also keeps an even-parity bit.
module instr_mem_bytearray
  import instr_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 512,
  parameter int INSTR_BYTES = 4,
  parameter bit BIG_ENDIAN  = 1'b1,
  parameter int IDX_W       = $clog2(DEPTH_BYTES)
) (
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [IDX_W-1:0]              i_waddr,
  input  logic [BYTE_W-1:0]             i_wdata,
`ifdef IMEM_PARITY_EN
  input  logic                          i_par_flip,
  output logic                          o_par_err,
`endif
  input  logic [IDX_W-1:0]              i_raddr,
  output logic [INSTR_BYTES*BYTE_W-1:0] o_rdata
);

  logic [BYTE_W-1:0] r_mem [DEPTH_BYTES];

  // Byte write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Gather INSTR_BYTES consecutive bytes into their endian-dependent lanes.
  always_comb begin
    o_rdata = '0;
    for (int k = 0; k < INSTR_BYTES; k++) begin
      o_rdata[byte_lane(k, INSTR_BYTES, BIG_ENDIAN)*BYTE_W +: BYTE_W] =
        r_mem[i_raddr + IDX_W'(k)];
    end
  end

`ifdef IMEM_PARITY_EN
  logic r_par [DEPTH_BYTES];

  // Store the even-parity bit; i_par_flip deliberately corrupts it.
  always_ff @(posedge clk) begin
    if (i_we) r_par[i_waddr] <= (^i_wdata) ^ i_par_flip;
  end

  // Flag the read if any gathered byte fails its parity check.
  always_comb begin
    logic w_acc;
    w_acc = 1'b0;
    for (int k = 0; k < INSTR_BYTES; k++) begin
      w_acc = w_acc | ((^r_mem[i_raddr + IDX_W'(k)]) ^ r_par[i_raddr + IDX_W'(k)]);
    end
    o_par_err = w_acc;
  end
`endif

endmodule

// File: rtl/instr_mem_fetch.sv
// Instruction memory with registered fetch output, valid/ready handshake,
// range/alignment error reporting and a saturating accepted-fetch counter.
// Optional macro IMEM_PARITY_EN enables per-byte parity and error code 11.
module instr_mem_fetch
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 512,
  parameter int INSTR_W     = 32,
  parameter int BIG_ENDIAN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              prog_par_flip,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic              fetch_err,
  output logic [1:0]        fetch_err_code,
  output logic [31:0]       fetch_cnt
);

  localparam int INSTR_BYTES = INSTR_W / BYTE_W;
  localparam int IDX_W       = $clog2(DEPTH_BYTES);
  // Address comparisons use one extra bit so the top of the space cannot wrap.
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [ADDR_W:0] LAST_OK  = (ADDR_W+1)'(DEPTH_BYTES - INSTR_BYTES);
  localparam logic [ADDR_W:0] OFF_MASK = (ADDR_W+1)'(INSTR_BYTES - 1);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_gnt;
  logic               w_prog_ok;
  logic [INSTR_W-1:0] w_rdata;
  logic               w_par_err;
  fetch_err_e         w_code;
  logic [INSTR_W-1:0] r_instr;
  logic               r_err;
  fetch_err_e         r_code;
  logic [31:0]        r_cnt;

  // Out-of-range programming writes are dropped here.
  assign w_prog_ok = prog_we & ({1'b0, prog_addr} < DEPTH_X);

  instr_mem_bytearray #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .INSTR_BYTES (INSTR_BYTES),
    .BIG_ENDIAN  (BIG_ENDIAN != 0),
    .IDX_W       (IDX_W)
  ) u_bytes (
    .clk        (clk),
    .i_we       (w_prog_ok),
    .i_waddr    (prog_addr[IDX_W-1:0]),
    .i_wdata    (prog_data),
`ifdef IMEM_PARITY_EN
    .i_par_flip (prog_par_flip),
    .o_par_err  (w_par_err),
`endif
    .i_raddr    (fetch_addr[IDX_W-1:0]),
    .o_rdata    (w_rdata)
  );

`ifndef IMEM_PARITY_EN
  logic w_unused_par_flip;
  assign w_par_err         = 1'b0;
  assign w_unused_par_flip = prog_par_flip;
`endif

  // Programming wins over fetch; a full output slot frees only when consumed.
  assign w_gnt       = fetch_req & ~prog_we & (~fetch_valid | fetch_ready);
  assign fetch_gnt   = w_gnt;
  assign fetch_valid = (r_state == ST_FULL);

  // Classify the fetch being accepted: range, then alignment, then parity.
  always_comb begin
    w_code = ERR_NONE;
    if ({1'b0, fetch_addr} > LAST_OK) begin
      w_code = ERR_RANGE;
    end else if (({1'b0, fetch_addr} & OFF_MASK) != '0) begin
      w_code = ERR_MISALIGN;
    end else if (w_par_err) begin
      w_code = ERR_PARITY;
    end
  end

  // Output slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Fill on grant, hold while unconsumed, otherwise drain.
  always_comb begin
    w_state_nxt = ST_EMPTY;
    if (w_gnt)                                      w_state_nxt = ST_FULL;
    else if ((r_state == ST_FULL) && !fetch_ready)  w_state_nxt = ST_FULL;
  end

  // Capture instruction and error status at accept; held until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '0;
      r_err   <= 1'b0;
      r_code  <= ERR_NONE;
    end else if (w_gnt) begin
      r_err   <= (w_code != ERR_NONE);
      r_code  <= w_code;
      r_instr <= (w_code == ERR_NONE) ? w_rdata : '0;
    end
  end

  // Count every accepted fetch, errored ones included, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_cnt <= '0;
    else if (w_gnt && (r_cnt != '1)) r_cnt <= r_cnt + 32'd1;
  end

  assign fetch_instr    = r_instr;
  assign fetch_err      = r_err;
  assign fetch_err_code = r_code;
  assign fetch_cnt      = r_cnt;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Bench for instr_mem_fetch: big- and little-endian instances share stimulus.
module tb_instr_mem_fetch;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic        prog_par_flip = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready = 1'b0;

  logic        gnt_b, valid_b, err_b, gnt_l, valid_l, err_l;
  logic [31:0] instr_b, instr_l, cnt_b, cnt_l;
  logic [1:0]  code_b, code_l;

  instr_mem_fetch #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .INSTR_W(32), .BIG_ENDIAN(1)) dut_be (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_par_flip(prog_par_flip), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .fetch_gnt(gnt_b), .fetch_valid(valid_b),
    .fetch_ready(fetch_ready), .fetch_instr(instr_b), .fetch_err(err_b),
    .fetch_err_code(code_b), .fetch_cnt(cnt_b));

  instr_mem_fetch #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .INSTR_W(32), .BIG_ENDIAN(0)) dut_le (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_par_flip(prog_par_flip), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .fetch_gnt(gnt_l), .fetch_valid(valid_l),
    .fetch_ready(fetch_ready), .fetch_instr(instr_l), .fetch_err(err_l),
    .fetch_err_code(code_l), .fetch_cnt(cnt_l));

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: byte image, corrupted-parity marks, expected output slot.
  logic [7:0]  m_mem [DEPTH];
  bit          m_bad [DEPTH];
  longint      m_cnt = 0;
  bit          e_valid = 1'b0;
  logic [31:0] e_be, e_le;
  logic [1:0]  e_code;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  code;
    logic [31:0] be;
    logic [31:0] le;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_expect(input logic [31:0] a, output logic [1:0] c,
                                       output logic [31:0] be, output logic [31:0] le);
    longint ua;
    int i;
    ua = longint'(a);
    c = 2'd0; be = '0; le = '0;
    if (ua > DEPTH - 4) c = 2'd2;
    else if (ua % 4 != 0) c = 2'd1;
    else begin
      i  = int'(ua);
      be = {m_mem[i], m_mem[i+1], m_mem[i+2], m_mem[i+3]};
      le = {m_mem[i+3], m_mem[i+2], m_mem[i+1], m_mem[i]};
`ifdef IMEM_PARITY_EN
      if (m_bad[i] | m_bad[i+1] | m_bad[i+2] | m_bad[i+3]) begin
        c = 2'd3; be = '0; le = '0;
      end
`endif
    end
  endfunction

  task automatic prog_byte(input logic [31:0] a, input logic [7:0] d, input logic f);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d; prog_par_flip = f;
    @(posedge clk);
    if (a < DEPTH) begin m_mem[a] = d; m_bad[a] = f; end
    #1;
    prog_we = 1'b0; prog_par_flip = 1'b0;
  endtask

  task automatic check_out(input string nm, input logic [1:0] c, input logic [31:0] be,
                           input logic [31:0] le);
    chk({nm, " valid"}, valid_b, 1);
    chk({nm, " instr_be"}, instr_b, be);
    chk({nm, " instr_le"}, instr_l, le);
    chk({nm, " err"}, err_b, (c != 0));
    chk({nm, " code"}, code_b, c);
    chk({nm, " cnt"}, cnt_b, m_cnt[31:0]);
  endtask

  task automatic fetch_one(input logic [31:0] a, input string nm);
    logic [1:0] c; logic [31:0] be, le;
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = a; fetch_ready = 1'b1;
    #1 chk({nm, " gnt"}, gnt_b, 1);
    model_expect(a, c, be, le);
    m_cnt++;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    check_out(nm, c, be, le);
  endtask

  initial begin
    logic [31:0] fx_addr [4];
    logic [31:0] fx_word [4];
    logic [31:0] w;
    logic [1:0]  c0, c1, c2;
    logic [31:0] b0, b1, b2, l0, l1, l2;
    bit          exp_gnt;

    vecs[0] = '{32'd0,        2'd0, 32'h0043_0820, 32'h2008_4300};
    vecs[1] = '{32'd4,        2'd0, 32'h1122_3344, 32'h4433_2211};
    vecs[2] = '{32'd8,        2'd0, 32'hA55A_C33C, 32'h3CC3_5AA5};
    vecs[3] = '{32'd508,      2'd0, 32'hDEAD_BEEF, 32'hEFBE_ADDE};
    vecs[4] = '{32'd2,        2'd1, 32'h0,         32'h0};
    vecs[5] = '{32'd511,      2'd2, 32'h0,         32'h0};
    vecs[6] = '{32'd512,      2'd2, 32'h0,         32'h0};
    vecs[7] = '{32'hFFFF_FFFE, 2'd2, 32'h0,        32'h0};
    vecs[8] = '{32'hFFFF_FFFC, 2'd2, 32'h0,        32'h0};
    fx_addr = '{32'd0, 32'd4, 32'd8, 32'd508};
    fx_word = '{32'h0043_0820, 32'h1122_3344, 32'hA55A_C33C, 32'hDEAD_BEEF};

    // Reset values
    #1;
    chk("rst valid", valid_b, 0);
    chk("rst instr", instr_b, 0);
    chk("rst err", err_b, 0);
    chk("rst code", code_b, 0);
    chk("rst cnt", cnt_b, 0);
    @(negedge clk); rst_n = 1'b1;

    // Program the whole image, then the fixed words (big-endian byte order)
    for (int a = 0; a < DEPTH; a++) prog_byte(a, 8'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) begin
      w = fx_word[i];
      for (int k = 0; k < 4; k++) prog_byte(fx_addr[i] + k, w[31-8*k -: 8], 1'b0);
    end

    // Table-driven single fetches
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      fetch_req = 1'b1; fetch_addr = vecs[i].addr; fetch_ready = 1'b1;
      #1 chk($sformatf("vec%0d gnt", i), gnt_b, 1);
      m_cnt++;
      @(posedge clk); #1;
      fetch_req = 1'b0;
      check_out($sformatf("vec%0d", i), vecs[i].code, vecs[i].be, vecs[i].le);
    end

    // Out-of-range write must not alias into the array
    prog_byte(32'd600, ~m_mem[88], 1'b0);
    fetch_one(32'd88, "oor_write");

    // Back-to-back fetches with a two-cycle consumer stall on the second word
    model_expect(32'd0, c0, b0, l0);
    model_expect(32'd4, c1, b1, l1);
    model_expect(32'd8, c2, b2, l2);
    @(negedge clk); fetch_req = 1'b1; fetch_addr = 32'd0; fetch_ready = 1'b1;
    m_cnt++;
    @(posedge clk); #1; check_out("b2b w0", c0, b0, l0);
    @(negedge clk); fetch_addr = 32'd4;
    m_cnt++;
    @(posedge clk); #1; check_out("b2b w1", c1, b1, l1);
    for (int h = 0; h < 2; h++) begin
      @(negedge clk); fetch_addr = 32'd8; fetch_ready = 1'b0;
      #1 chk("stall gnt", gnt_b, 0);
      @(posedge clk); #1; check_out("stall hold", c1, b1, l1);
    end
    @(negedge clk); fetch_ready = 1'b1;
    #1 chk("resume gnt", gnt_b, 1);
    m_cnt++;
    @(posedge clk); #1; check_out("b2b w2", c2, b2, l2);
    @(negedge clk); fetch_req = 1'b0;
    @(posedge clk); #1; chk("drain valid", valid_b, 0);

    // Programming has priority over a same-cycle fetch
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 32'd4; prog_data = 8'h99;
    fetch_req = 1'b1; fetch_addr = 32'd4; fetch_ready = 1'b1;
    #1 chk("prio gnt", gnt_b, 0);
    @(posedge clk); m_mem[4] = 8'h99; m_bad[4] = 1'b0;
    #1 prog_we = 1'b0;
    fetch_one(32'd4, "prio new byte");

    // Corrupted parity on byte 5 (only reported when parity is built in)
    prog_byte(32'd5, m_mem[5], 1'b1);
    fetch_one(32'd4, "parity");
    prog_byte(32'd5, m_mem[5], 1'b0);

    // Randomised traffic against the reference model
    @(negedge clk); fetch_req = 1'b0; fetch_ready = 1'b1;
    @(posedge clk); e_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      prog_we       = ($urandom_range(0, 7) == 0);
      prog_addr     = $urandom_range(0, 599);
      prog_data     = 8'($urandom);
      prog_par_flip = ($urandom_range(0, 3) == 0);
      fetch_req     = ($urandom_range(0, 3) != 0);
      fetch_ready   = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0, 1:    fetch_addr = 32'($urandom_range(0, 127)) * 4;
        2:       fetch_addr = $urandom_range(0, 511);
        default: fetch_addr = $urandom;
      endcase
      exp_gnt = fetch_req && !prog_we && (!e_valid || fetch_ready);
      #1 chk("rnd gnt", gnt_b, exp_gnt);
      @(posedge clk);
      if (exp_gnt) begin
        model_expect(fetch_addr, e_code, e_be, e_le);
        e_valid = 1'b1;
        m_cnt++;
      end else if (!(e_valid && !fetch_ready)) begin
        e_valid = 1'b0;
      end
      if (prog_we && prog_addr < DEPTH) begin
        m_mem[prog_addr] = prog_data;
        m_bad[prog_addr] = prog_par_flip;
      end
      #1;
      chk("rnd valid", valid_b, e_valid);
      if (e_valid) begin
        chk("rnd instr_be", instr_b, e_be);
        chk("rnd instr_le", instr_l, e_le);
        chk("rnd code", code_b, e_code);
        chk("rnd err", err_b, (e_code != 0));
      end
      chk("rnd cnt", cnt_b, m_cnt[31:0]);
    end
    @(negedge clk);
    prog_we = 1'b0; prog_par_flip = 1'b0; fetch_req = 1'b0; fetch_ready = 1'b1;
    @(posedge clk);

    // Asynchronous reset while an errored response is held
    fetch_one(32'd2, "pre-reset");
    fetch_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async valid", valid_b, 0);
    chk("async err", err_b, 0);
    chk("async code", code_b, 0);
    chk("async instr", instr_b, 0);
    chk("async cnt", cnt_b, 0);
    m_cnt = 0;
    @(negedge clk); rst_n = 1'b1;
    fetch_one(32'd8, "post-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
